// File: rtl/mcse_ipid_pkg.sv
// Shared types and constants for the MCSE IP ID collector: FSM states,
// frame delimiters and error codes.
package mcse_ipid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    TRL,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] IPID_HDR = 16'h7A7A;
  localparam logic [15:0] IPID_TRL = 16'hB9B9;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_DROP = 2'd2;
  localparam logic [1:0] ERR_TRL  = 2'd3;

endpackage

// File: rtl/mcse_ipid_collector.sv
// Requests IPID_N IP IDs from the host over GPIO, checks the framing of each
// reply and hands the assembled IDs to the MCSE controller one at a time.
module mcse_ipid_collector
  import mcse_ipid_pkg::*;
#(
  parameter int IPID_N      = 3,
  parameter int IPID_WIDTH  = 256,
  parameter int WORD_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ipid_trigger,
  output logic [3:0]            ipid_addr,
  input  logic                  ipid_valid_in,
  input  logic [WORD_W-1:0]     ipid_word_in,
  output logic [IPID_WIDTH-1:0] ipid_out,
  output logic                  ipid_out_valid,
  output logic [3:0]            ipid_out_idx,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code
);

  localparam int NW     = IPID_WIDTH / WORD_W;
  localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NW - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(IPID_N - 1);
  localparam logic [WORD_W-1:0] HDR_WORD  = WORD_W'(IPID_HDR);
  localparam logic [WORD_W-1:0] TRL_WORD  = WORD_W'(IPID_TRL);

  state_t                  state_reg;
  logic [3:0]              idx_reg;
  logic [WCNT_W-1:0]       wcnt_reg;
  logic [TCNT_W-1:0]       tcnt_reg;
  logic [1:0]              gap_reg;
  logic [IPID_WIDTH-1:0]   shift_reg;

  logic start_ok;
  assign start_ok = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      wcnt_reg       <= '0;
      tcnt_reg       <= '0;
      gap_reg        <= '0;
      shift_reg      <= '0;
      ipid_trigger   <= 1'b0;
      ipid_addr      <= '0;
      ipid_out       <= '0;
      ipid_out_valid <= 1'b0;
      ipid_out_idx   <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      error_code     <= ERR_NONE;
    end else begin
      ipid_out_valid <= 1'b0;
      if (start_ok) begin
        state_reg    <= REQ;
        idx_reg      <= '0;
        ipid_addr    <= '0;
        ipid_trigger <= 1'b1;
        tcnt_reg     <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
        error_code   <= ERR_NONE;
      end else begin
        case (state_reg)
          REQ: begin
            if (ipid_valid_in) begin
              if (ipid_word_in == HDR_WORD) begin
                state_reg <= DATA;
                wcnt_reg  <= '0;
              end else begin
                state_reg    <= ERR;
                ipid_trigger <= 1'b0;
                error        <= 1'b1;
                error_code   <= ERR_HDR;
              end
            end else if (tcnt_reg == TCNT_LAST) begin
              state_reg    <= ERR;
              ipid_trigger <= 1'b0;
              error        <= 1'b1;
              error_code   <= ERR_TRL;
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
          DATA: begin
            if (!ipid_valid_in) begin
              state_reg    <= ERR;
              ipid_trigger <= 1'b0;
              error        <= 1'b1;
              error_code   <= ERR_DROP;
            end else begin
              // First word ends up in the MSB slice after NW shifts.
              shift_reg <= {shift_reg[IPID_WIDTH-WORD_W-1:0], ipid_word_in};
              if (wcnt_reg == WCNT_LAST) state_reg <= TRL;
              else wcnt_reg <= wcnt_reg + 1'b1;
            end
          end
          TRL: begin
            ipid_trigger <= 1'b0;
            if (ipid_valid_in && ipid_word_in == TRL_WORD) begin
              state_reg      <= GAP;
              ipid_out       <= shift_reg;
              ipid_out_valid <= 1'b1;
              ipid_out_idx   <= idx_reg;
              gap_reg        <= '0;
            end else begin
              state_reg  <= ERR;
              error      <= 1'b1;
              error_code <= ERR_TRL;
            end
          end
          GAP: begin
            if (gap_reg != 2'd3) gap_reg <= gap_reg + 1'b1;
            // Third GAP edge at the earliest keeps trigger low for 3 cycles.
            if (gap_reg >= 2'd2 && !ipid_valid_in) begin
              if (idx_reg == IDX_LAST) begin
                state_reg <= DONE;
                done      <= 1'b1;
              end else begin
                state_reg    <= REQ;
                idx_reg      <= idx_reg + 1'b1;
                ipid_addr    <= idx_reg + 1'b1;
                ipid_trigger <= 1'b1;
                tcnt_reg     <= '0;
              end
            end
          end
          IDLE, DONE, ERR: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcse_ipid_collector.sv
// Randomized host model with scoreboard for mcse_ipid_collector.
module tb_mcse_ipid_collector;
  localparam int IPID_N      = 3;
  localparam int IPID_WIDTH  = 256;
  localparam int WORD_W      = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int NW          = IPID_WIDTH / WORD_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  ipid_trigger;
  logic [3:0]            ipid_addr;
  logic                  ipid_valid_in;
  logic [WORD_W-1:0]     ipid_word_in;
  logic [IPID_WIDTH-1:0] ipid_out;
  logic                  ipid_out_valid;
  logic [3:0]            ipid_out_idx;
  logic                  done;
  logic                  error;
  logic [1:0]            error_code;

  mcse_ipid_collector #(
    .IPID_N(IPID_N), .IPID_WIDTH(IPID_WIDTH), .WORD_W(WORD_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ipid_trigger(ipid_trigger), .ipid_addr(ipid_addr),
    .ipid_valid_in(ipid_valid_in), .ipid_word_in(ipid_word_in),
    .ipid_out(ipid_out), .ipid_out_valid(ipid_out_valid), .ipid_out_idx(ipid_out_idx),
    .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]            idx;
    logic [IPID_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [IPID_WIDTH-1:0] last_out = '0;

  task automatic check(input string name, input logic [IPID_WIDTH-1:0] act,
                       input logic [IPID_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: every ID pulse must match the oldest expected completed frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ipid_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ipid_out_valid: got idx %0d expected no pulse", ipid_out_idx);
      end else begin
        e = exp_q.pop_front();
        check("ipid_out", ipid_out, e.data);
        check("ipid_out_idx", 256'(ipid_out_idx), 256'(e.idx));
        last_out = e.data;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // kind: 0 nominal, 1 bad header, 2 valid drop after 7 words,
  //       3 bad trailer, 4 reset after 9 words
  task automatic frame(input int idx, input int kind);
    logic [WORD_W-1:0]     words[NW];
    logic [IPID_WIDTH-1:0] expd;
    exp_t                  e;
    int                    d;
    for (int i = 0; i < 100; i++) begin
      if (ipid_trigger === 1'b1) break;
      @(posedge clk); #1;
    end
    check("ipid_trigger_rise", 256'(ipid_trigger), 256'(1));
    check("ipid_addr", 256'(ipid_addr), 256'(idx));
    d = $urandom_range(0, 4);
    repeat (d) begin @(posedge clk); #1; end
    expd = '0;
    for (int i = 0; i < NW; i++) begin
      words[i] = 16'($urandom_range(0, 65535));
      expd[IPID_WIDTH-1-WORD_W*i -: WORD_W] = words[i];
    end
    ipid_valid_in = 1'b1;
    ipid_word_in  = (kind == 1) ? 16'h1234 : 16'h7A7A;
    @(posedge clk); #1;
    if (kind == 1) begin
      ipid_valid_in = 1'b0;
      return;
    end
    for (int i = 0; i < NW; i++) begin
      if (kind == 2 && i == 7) begin
        ipid_valid_in = 1'b0;
        return;
      end
      if (kind == 4 && i == 9) begin
        rst = 1'b1;
        #1;
        check("rst_trigger", 256'(ipid_trigger), 256'(0));
        check("rst_addr", 256'(ipid_addr), 256'(0));
        check("rst_ipid_out", ipid_out, 256'(0));
        check("rst_out_valid", 256'(ipid_out_valid), 256'(0));
        check("rst_out_idx", 256'(ipid_out_idx), 256'(0));
        check("rst_error", 256'({error, error_code, done}), 256'(0));
        last_out = '0;
        ipid_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      ipid_word_in = words[i];
      @(posedge clk); #1;
    end
    ipid_word_in = (kind == 3) ? 16'hB9B8 : 16'hB9B9;
    if (kind == 0) begin
      e.idx  = 4'(idx);
      e.data = expd;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ipid_valid_in = 1'b0;
    ipid_word_in  = 16'($urandom_range(0, 65535));
  endtask

  task automatic full_boot(input string tag);
    do_start();
    check({tag, "_error_cleared"}, 256'(error), 256'(0));
    for (int k = 0; k < IPID_N; k++) frame(k, 0);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_done"}, 256'(done), 256'(1));
    check({tag, "_trigger_low"}, 256'(ipid_trigger), 256'(0));
    check({tag, "_pending"}, 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    ipid_valid_in = 1'b0;
    ipid_word_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_trigger", 256'(ipid_trigger), 256'(0));
    check("reset_outputs", 256'({ipid_addr, ipid_out_valid, ipid_out_idx, done, error, error_code}), 256'(0));
    check("reset_ipid_out", ipid_out, 256'(0));
    rst = 1'b0;

    full_boot("nominal");

    do_start();
    frame(0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("badhdr_error", 256'(error), 256'(1));
    check("badhdr_code", 256'(error_code), 256'(1));
    check("badhdr_trigger", 256'(ipid_trigger), 256'(0));

    do_start();
    frame(0, 2);
    repeat (2) @(posedge clk);
    #1;
    check("drop_error", 256'(error), 256'(1));
    check("drop_code", 256'(error_code), 256'(2));

    full_boot("recover");

    do_start();
    frame(0, 3);
    repeat (2) @(posedge clk);
    #1;
    check("badtrl_code", 256'(error_code), 256'(3));
    check("badtrl_ipid_kept", ipid_out, last_out);

    do_start();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (error === 1'b1) break;
    end
    check("timeout_cycles", 256'(n), 256'(TIMEOUT_CYC));
    check("timeout_code", 256'(error_code), 256'(3));

    do_start();
    frame(0, 4);
    full_boot("after_rst");

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcse_ipid_collector.md
# mcse_ipid_collector

Host-facing IP ID receiver inside the MCSE, directly downstream of the host GPIO pins. It issues a per-IP request (trigger plus IP address), accepts a framed 16-bit word stream from the host, strips and checks the 0x7A7A header and 0xB9B9 trailer, and assembles each 256-bit IP ID. It then hands each assembled ID to the MCSE controller, one per IP, for IPID_N IPs.

## Interface
Parameters:
- IPID_N, 3, number of IP IDs collected per boot (max 16)
- IPID_WIDTH, 256, bits per IP ID; must be a multiple of WORD_W
- WORD_W, 16, width of one GPIO data word
- TIMEOUT_CYC, 4096, cycles allowed from trigger rise to header before error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from MCSE controller; begins collection at index 0
- ipid_trigger  out  1  request to host; maps to gpio_out[12]
- ipid_addr  out  4  index of the IP ID being requested; maps to gpio_out[11:8]
- ipid_valid_in  in  1  host frame-valid; maps to gpio_in[13]
- ipid_word_in  in  WORD_W  host data word; maps to gpio_in[31:16]
- ipid_out  out  IPID_WIDTH  assembled IP ID; stable until the next ipid_out_valid
- ipid_out_valid  out  1  one-cycle pulse; ipid_out is complete
- ipid_out_idx  out  4  index belonging to ipid_out
- done  out  1  level; all IPID_N IDs received without error
- error  out  1  sticky level; cleared by start or rst
- error_code  out  2  cause: 1 = bad header, 2 = valid dropped mid-frame, 3 = bad trailer or timeout

## Operation
- Frame: header 0x7A7A, then NW = IPID_WIDTH/WORD_W data words (16 by default), then trailer 0xB9B9. ipid_valid_in is held high for all NW+2 words. One word is sampled per clk.
- Packing: the first data word goes to ipid_out[IPID_WIDTH-1 -: WORD_W], and each following word goes to the next lower slice. The last data word goes to [WORD_W-1:0]. Assembly uses a shift register; ipid_out is updated only when the trailer passes its check.
- FSM states:
  - IDLE: on start, go to REQ with idx=0. Clear done, error and error_code.
  - REQ: ipid_trigger=1 and ipid_addr=idx. The timeout counter runs. On the first sampled ipid_valid_in=1:
    - word = 0x7A7A: go to DATA with the word count at 0.
    - any other word: go to ERR, code 1.
  - DATA: every cycle, require ipid_valid_in=1 and shift in the word. After NW words, go to TRL. If valid is 0, go to ERR, code 2.
  - TRL: valid=1 and word=0xB9B9: load ipid_out, pulse ipid_out_valid, drive ipid_out_idx=idx, go to GAP. Any other word, or valid=0, goes to ERR, code 3.
  - GAP: ipid_trigger=0. Wait until ipid_valid_in is sampled 0 and at least 2 cycles have passed in GAP.
    - idx == IPID_N-1: go to DONE.
    - otherwise: idx+1, go to REQ.
  - DONE: done=1 and ipid_trigger=0. start re-enters REQ with idx=0.
  - ERR: ipid_trigger=0 and error=1. Only start (to REQ, idx=0, error cleared) or rst leaves this state.
- Timeout: if no header arrives within TIMEOUT_CYC cycles of entering REQ, go to ERR, code 3.
- start outside IDLE, DONE or ERR is ignored.
- ipid_valid_in=1 outside REQ, DATA or TRL is ignored.

## Timing
- Reset values:
  - ipid_trigger=0, ipid_addr=0
  - ipid_out=0, ipid_out_valid=0, ipid_out_idx=0
  - done=0, error=0, error_code=0
  - state IDLE
- All outputs are registered.
- ipid_trigger rises the cycle after start is sampled.
- Header sampled at edge t: data words are sampled at t+1 through t+NW and the trailer at t+NW+1.
- ipid_out_valid and the ipid_trigger fall both occur in the cycle after the trailer edge.
- ipid_trigger re-rises no earlier than 3 cycles after it fell, and only after valid has been seen low.
- rst mid-frame: the partial ID is discarded and no ipid_out_valid is issued.

## Structure
- Shared package mcse_ipid_pkg holds:
  - state enum (IDLE, REQ, DATA, TRL, GAP, DONE, ERR)
  - IPID_HDR=16'h7A7A and IPID_TRL=16'hB9B9
  - error-code localparams
- Single module. No sub-module is warranted; the FSM, shift register, word counter and timeout counter share a single always_ff.

## Test plan
- Nominal: start, then 3 frames of 7A7A + 16 words + B9B9. Expect:
  - 3 ipid_out_valid pulses with idx 0, 1, 2
  - ipid_addr 0, 1, 2 during the corresponding requests
  - first word lands in ipid_out[255:240]
  - done=1 and ipid_trigger=0 at the end
- Bad header: first valid word 0x1234 → error=1, error_code=1, ipid_trigger=0, no ipid_out_valid.
- Valid drop: valid deasserted after data word 7 → error_code=2. A later start recovers, and a nominal frame then yields ipid_out_valid with idx 0.
- Bad trailer: final word 0xB9B8 → error_code=3, ipid_out keeps its previous value.
- Timeout: TIMEOUT_CYC=64 with no host response → error_code=3 on cycle 64 after trigger rise.
- Reset mid-DATA: assert rst at word 9 → all outputs return to reset values immediately. After release and start, a full frame is collected correctly.
